// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the 5-stage MIPS core.
// Carries GPR/HI/LO write results to MEM and keeps the madd/msub partial state for EX.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_ex,
    input  logic                  stall_mem,
    input  logic                  ex_we,
    input  logic [ADDR_W-1:0]     ex_w_addr,
    input  logic [DATA_W-1:0]     ex_w_data,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_hilo,
    input  logic [2*DATA_W-1:0]   hilo_temp_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_w_addr,
    output logic [DATA_W-1:0]     mem_w_data,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_hilo,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o
);

    logic                  r_we,   w_we;
    logic [ADDR_W-1:0]     r_addr, w_addr;
    logic [DATA_W-1:0]     r_data, w_data;
    logic [DATA_W-1:0]     r_hi,   w_hi;
    logic [DATA_W-1:0]     r_lo,   w_lo;
    logic                  r_hilo, w_hilo;
    logic [2*DATA_W-1:0]   r_temp, w_temp;
    logic [CNT_W-1:0]      r_cnt,  w_cnt;

    // Priority: flush > MEM hold > EX bubble (keeps madd/msub state) > pass.
    always_comb begin
        w_we   = r_we;
        w_addr = r_addr;
        w_data = r_data;
        w_hi   = r_hi;
        w_lo   = r_lo;
        w_hilo = r_hilo;
        w_temp = r_temp;
        w_cnt  = r_cnt;
        if (flush) begin
            w_we   = 1'b0;
            w_addr = '0;
            w_data = '0;
            w_hi   = '0;
            w_lo   = '0;
            w_hilo = 1'b0;
            w_temp = '0;
            w_cnt  = '0;
        end else if (stall_mem) begin
            // hold everything
        end else if (stall_ex) begin
            w_we   = 1'b0;
            w_addr = '0;
            w_data = '0;
            w_hi   = '0;
            w_lo   = '0;
            w_hilo = 1'b0;
            w_temp = hilo_temp_i;
            w_cnt  = cnt_i;
        end else begin
            w_we   = ex_we;
            w_addr = ex_w_addr;
            w_data = ex_w_data;
            w_hi   = ex_hi;
            w_lo   = ex_lo;
            w_hilo = ex_hilo;
            w_temp = '0;
            w_cnt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_hilo <= 1'b0;
            r_temp <= '0;
            r_cnt  <= '0;
        end else begin
            r_we   <= w_we;
            r_addr <= w_addr;
            r_data <= w_data;
            r_hi   <= w_hi;
            r_lo   <= w_lo;
            r_hilo <= w_hilo;
            r_temp <= w_temp;
            r_cnt  <= w_cnt;
        end
    end

    assign mem_we      = r_we;
    assign mem_w_addr  = r_addr;
    assign mem_w_data  = r_data;
    assign mem_hi      = r_hi;
    assign mem_lo      = r_lo;
    assign mem_hilo    = r_hilo;
    assign hilo_temp_o = r_temp;
    assign cnt_o       = r_cnt;

endmodule
